// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher_pkg
//   Shared definitions for the scope command dispatcher: default command
//   codes, the idle display code, abort/NAK bytes and the dispatcher FSM
//   state type.
//   No ports (package).
package cmd_dispatcher_pkg;

   localparam logic [7:0] CMD_IDLE        = 8'h00;
   localparam logic [7:0] CMD_TEST        = 8'h74;
   localparam logic [7:0] CMD_SAMPLER     = 8'h11;
   localparam logic [7:0] CMD_SAMPLE_READ = 8'h21;
   localparam logic [7:0] CMD_REPLAYER    = 8'h71;
   localparam logic [7:0] CMD_REPLY_CNT   = 8'h72;

   localparam logic [7:0] ABORT_BYTE      = 8'h1B;
   localparam logic [7:0] NAK_DEFAULT     = 8'h15;

   // Channel i owns bits [8i+7:8i].
   localparam logic [31:0] DEFAULT_CMD_CODES =
      {CMD_REPLY_CNT, CMD_REPLAYER, CMD_SAMPLE_READ, CMD_SAMPLER};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_NAK_SEND,
      S_NAK_WAIT
   } disp_state_e;

endpackage

// File: rtl/cmd_dispatcher_if.sv
// cmd_dispatcher_if
//   Bundles the UART rx/tx handshake, the per-channel unit bus and the
//   status outputs of the command dispatcher.
//   master : dispatcher side (drives tx_*, ch_activate, state and pulses)
//   slave  : environment side (uart_rx/uart_tx and the function units)
interface cmd_dispatcher_if #(
   parameter int unsigned N_CH = 4
);

   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              tx_active;
   logic              tx_done;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic [N_CH-1:0]   ch_activate;
   logic [N_CH-1:0]   ch_done;
   logic [N_CH*8-1:0] ch_tx_data;
   logic [N_CH-1:0]   ch_tx_start;
   logic [7:0]        state;
   logic              timeout;
   logic              aborted;
   logic              nak;

   modport master (
      input  rx_ready, rx_data, tx_active, tx_done,
             ch_done, ch_tx_data, ch_tx_start,
      output tx_data, tx_start, ch_activate, state,
             timeout, aborted, nak
   );

   modport slave (
      output rx_ready, rx_data, tx_active, tx_done,
             ch_done, ch_tx_data, ch_tx_start,
      input  tx_data, tx_start, ch_activate, state,
             timeout, aborted, nak
   );

endinterface

// File: rtl/cmd_dispatcher_watchdog.sv
// cmd_dispatcher_watchdog
//   Cycle counter bounding how long a channel may stay active.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : reload the counter with zero (channel entry)
//   en         : count this cycle (channel active)
//   expire     : high in the cycle the count reaches TIMEOUT-1; never
//                asserted when TIMEOUT is 0
module cmd_dispatcher_watchdog #(
   parameter logic [31:0] TIMEOUT = 32'd0
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (TIMEOUT != 32'd0) && en && !clr && (cnt_q == TIMEOUT - 32'd1);

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher
//   UART command dispatcher and tx arbiter. A command byte received while
//   idle activates one function-unit channel; while active the unit owns
//   uart_tx through a registered mux. The channel is released on its done
//   flag, on the abort byte or on watchdog expiry. Unknown commands are
//   answered with a single NAK byte.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : cmd_dispatcher_if.master (rx strobe/data, tx handshake,
//           per-channel activate/done/tx bus, state code and event pulses)
module cmd_dispatcher
   import cmd_dispatcher_pkg::*;
#(
   parameter int unsigned        N_CH       = 4,
   parameter logic [N_CH*8-1:0]  CMD_CODES  = DEFAULT_CMD_CODES,
   parameter logic [31:0]        TIMEOUT    = 32'd0,
   parameter logic [7:0]         ABORT_CODE = ABORT_BYTE,
   parameter logic [7:0]         NAK_BYTE   = NAK_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   cmd_dispatcher_if.master  bus
);

   localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   disp_state_e      fsm_q, fsm_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_CH-1:0]  ch_activate_q, ch_activate_d;
   logic [7:0]       state_q, state_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             timeout_q, timeout_d;
   logic             aborted_q, aborted_d;
   logic             nak_q, nak_d;

   logic [N_CH-1:0]  match;
   logic             hit;
   logic [SEL_W-1:0] hit_idx;
   logic             act_done;
   logic             abort_hit;
   logic [7:0]       act_tx_data;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_expire;

   // Command decode: one comparator per channel.
   for (genvar g = 0; g < N_CH; g++) begin : g_match
      assign match[g] = (bus.rx_data == CMD_CODES[8*g +: 8]);
   end

   // Priority encoder, lowest channel index wins on duplicate codes.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (match[i] && !hit) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   assign act_done    = bus.ch_done[sel_q];
   assign abort_hit   = bus.rx_ready && (bus.rx_data == ABORT_CODE);
   assign act_tx_data = bus.ch_tx_data[sel_q*8 +: 8];
   assign wd_en       = (fsm_q == S_ACTIVE);

   cmd_dispatcher_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   always_comb begin
      fsm_d         = fsm_q;
      sel_d         = sel_q;
      ch_activate_d = ch_activate_q;
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      timeout_d     = 1'b0;
      aborted_d     = 1'b0;
      nak_d         = 1'b0;
      wd_clr        = 1'b0;

      unique case (fsm_q)
         S_IDLE: begin
            if (bus.rx_ready && (bus.rx_data != CMD_IDLE) && (bus.rx_data != ABORT_CODE)) begin
               if (hit) begin
                  fsm_d                  = S_ACTIVE;
                  sel_d                  = hit_idx;
                  ch_activate_d          = '0;
                  ch_activate_d[hit_idx] = 1'b1;
                  state_d                = bus.rx_data;
                  wd_clr                 = 1'b1;
               end else begin
                  nak_d = 1'b1;
                  fsm_d = S_NAK_SEND;
               end
            end
         end

         S_ACTIVE: begin
            // The mux follows the channel through its final cycle, so a
            // start strobe issued together with done is still forwarded.
            tx_data_d  = act_tx_data;
            tx_start_d = bus.ch_tx_start[sel_q];
            if (act_done || abort_hit || wd_expire) begin
               fsm_d         = S_IDLE;
               ch_activate_d = '0;
               state_d       = CMD_IDLE;
            end
            if (!act_done) begin
               if (abort_hit) begin
                  aborted_d = 1'b1;
               end else if (wd_expire) begin
                  timeout_d = 1'b1;
               end
            end
         end

         S_NAK_SEND: begin
            if (!bus.tx_active) begin
               tx_start_d = 1'b1;
               tx_data_d  = NAK_BYTE;
               fsm_d      = S_NAK_WAIT;
            end
         end

         S_NAK_WAIT: begin
            if (bus.tx_done) begin
               fsm_d = S_IDLE;
            end
         end

         default: begin
            fsm_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q         <= S_IDLE;
         sel_q         <= '0;
         ch_activate_q <= '0;
         state_q       <= CMD_IDLE;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         timeout_q     <= 1'b0;
         aborted_q     <= 1'b0;
         nak_q         <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         sel_q         <= sel_d;
         ch_activate_q <= ch_activate_d;
         state_q       <= state_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         timeout_q     <= timeout_d;
         aborted_q     <= aborted_d;
         nak_q         <= nak_d;
      end
   end

   assign bus.ch_activate = ch_activate_q;
   assign bus.state       = state_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.timeout     = timeout_q;
   assign bus.aborted     = aborted_q;
   assign bus.nak         = nak_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher
//   Self-checking bench for cmd_dispatcher: directed vector table, hand
//   sequences for NAK, watchdog and reset, then randomized traffic against
//   a behavioural reference model.
module tb_cmd_dispatcher;

   localparam int unsigned N_CH  = 4;
   localparam logic [31:0] CODES = 32'h7271_2111;
   localparam logic [31:0] TMO   = 32'd100;
   localparam logic [31:0] D     = 32'h33A5_4455;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cmd_dispatcher_if #(.N_CH(N_CH)) bif ();

   cmd_dispatcher #(
      .N_CH       (N_CH),
      .CMD_CODES  (CODES),
      .TIMEOUT    (TMO),
      .ABORT_CODE (8'h1B),
      .NAK_BYTE   (8'h15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.master)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rx_ready;
      logic [7:0] rx_data;
      logic [3:0] ch_done;
      logic [3:0] ch_tx_start;
      logic [3:0] e_act;
      logic [7:0] e_state;
      logic       e_txs;
      logic [7:0] e_txd;
      logic       e_ab;
   } vec_t;

   vec_t vecs[$];

   // reference model
   logic [7:0] code_arr [4] = '{8'h11, 8'h21, 8'h71, 8'h72};
   int         m_mode;   // 0 idle, 1 channel active, 2 NAK pending, 3 NAK in flight
   int         m_ch;
   int         m_age;    // active cycles already completed
   logic [3:0] e_act;
   logic [7:0] e_state, e_txd;
   logic       e_txs, e_nak, e_ab, e_to;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] act, input logic [7:0] st,
                             input logic txs, input logic [7:0] txd, input logic nk,
                             input logic ab, input logic to);
      chk({tag, ".ch_activate"}, 32'(bif.ch_activate), 32'(act));
      chk({tag, ".state"},       32'(bif.state),       32'(st));
      chk({tag, ".tx_start"},    32'(bif.tx_start),    32'(txs));
      chk({tag, ".tx_data"},     32'(bif.tx_data),     32'(txd));
      chk({tag, ".nak"},         32'(bif.nak),         32'(nk));
      chk({tag, ".aborted"},     32'(bif.aborted),     32'(ab));
      chk({tag, ".timeout"},     32'(bif.timeout),     32'(to));
   endtask

   task automatic idle_inputs();
      bif.rx_ready    = 1'b0;
      bif.rx_data     = 8'h00;
      bif.tx_active   = 1'b0;
      bif.tx_done     = 1'b0;
      bif.ch_done     = '0;
      bif.ch_tx_start = '0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_ch = 0; m_age = 0;
      e_act = '0; e_state = '0; e_txd = '0;
      e_txs = 0; e_nak = 0; e_ab = 0; e_to = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      bif.ch_tx_data = '0;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   // Predicts the outputs after the coming clock edge from the inputs now applied.
   task automatic model_step();
      int  hit;
      bit  leave;
      e_nak = 0; e_ab = 0; e_to = 0; e_txs = 0;
      leave = 0;
      case (m_mode)
         0: begin
            if (bif.rx_ready && bif.rx_data != 8'h00 && bif.rx_data != 8'h1B) begin
               hit = -1;
               for (int i = 3; i >= 0; i--) if (code_arr[i] == bif.rx_data) hit = i;
               if (hit >= 0) begin
                  m_mode = 1; m_ch = hit; m_age = 0;
                  e_act = 4'(1 << hit);
                  e_state = bif.rx_data;
               end else begin
                  e_nak = 1; m_mode = 2;
               end
            end
         end
         1: begin
            e_txd = bif.ch_tx_data[m_ch*8 +: 8];
            e_txs = bif.ch_tx_start[m_ch];
            if (bif.ch_done[m_ch]) leave = 1;
            else if (bif.rx_ready && bif.rx_data == 8'h1B) begin leave = 1; e_ab = 1; end
            else if (m_age + 1 == int'(TMO)) begin leave = 1; e_to = 1; end
            else m_age++;
            if (leave) begin m_mode = 0; e_act = '0; e_state = 8'h00; end
         end
         2: begin
            if (!bif.tx_active) begin e_txs = 1; e_txd = 8'h15; m_mode = 3; end
         end
         default: begin
            if (bif.tx_done) m_mode = 0;
         end
      endcase
   endtask

   task automatic rand_inputs(input bit calm);
      int unsigned r;
      bif.rx_ready = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 7);
      if (r < 4)       bif.rx_data = code_arr[$urandom_range(0, 3)];
      else if (r == 4) bif.rx_data = calm ? 8'h00 : 8'h1B;
      else if (r == 5) bif.rx_data = 8'h00;
      else             bif.rx_data = 8'($urandom);
      bif.tx_active = ($urandom_range(0, 2) == 0);
      bif.tx_done   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 4; i++)
         bif.ch_done[i] = calm ? ($urandom_range(0, 249) == 0) : ($urandom_range(0, 59) == 0);
      bif.ch_tx_start = 4'($urandom);
      bif.ch_tx_data  = $urandom;
   endtask

   initial begin
      int n;
      int pulses;

      // ---------------- reset state ----------------
      reset = 1'b1;
      idle_inputs();
      bif.ch_tx_data = '0;
      tick();
      tick();
      check_outs("reset", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      check_outs("post_reset", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // ---------------- vector table ----------------
      vecs.push_back('{1'b1, 8'h71, 4'b0000, 4'b0000, 4'b0100, 8'h71, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 4'b1011, 4'b0100, 8'h71, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 4'b0100, 4'b0100, 8'h71, 1'b1, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b1011, 4'b0000, 4'b0100, 8'h71, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{1'b1, 8'h21, 4'b0000, 4'b0000, 4'b0100, 8'h71, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0100, 4'b0100, 4'b0000, 8'h00, 1'b1, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 8'h00, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{1'b1, 8'h72, 4'b0000, 4'b0000, 4'b1000, 8'h72, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{1'b1, 8'h21, 4'b0000, 4'b0000, 4'b1000, 8'h72, 1'b0, 8'h33, 1'b0});
      vecs.push_back('{1'b1, 8'h1B, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h33, 1'b1});
      vecs.push_back('{1'b1, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h33, 1'b0});
      vecs.push_back('{1'b1, 8'h1B, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h33, 1'b0});
      vecs.push_back('{1'b1, 8'h11, 4'b0000, 4'b0000, 4'b0001, 8'h11, 1'b0, 8'h33, 1'b0});
      vecs.push_back('{1'b1, 8'h1B, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h55, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h55, 1'b0});
      vecs.push_back('{1'b1, 8'h21, 4'b0000, 4'b0000, 4'b0010, 8'h21, 1'b0, 8'h55, 1'b0});
      vecs.push_back('{1'b1, 8'h72, 4'b0010, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h44, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h44, 1'b0});

      bif.ch_tx_data = D;
      foreach (vecs[i]) begin
         bif.rx_ready    = vecs[i].rx_ready;
         bif.rx_data     = vecs[i].rx_data;
         bif.ch_done     = vecs[i].ch_done;
         bif.ch_tx_start = vecs[i].ch_tx_start;
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].e_act, vecs[i].e_state, vecs[i].e_txs,
                    vecs[i].e_txd, 1'b0, vecs[i].e_ab, 1'b0);
      end
      idle_inputs();

      // ---------------- watchdog expiry ----------------
      bif.rx_ready = 1'b1; bif.rx_data = 8'h21;
      tick();
      idle_inputs();
      chk("wd.activate", 32'(bif.ch_activate), 32'h2);
      n = 0; pulses = 0;
      do begin
         tick();
         n++;
         if (bif.timeout) pulses++;
      end while (bif.ch_activate != 4'b0000 && n < 300);
      chk("wd.latency", 32'(n), 32'd100);
      chk("wd.pulse_at_exit", 32'(bif.timeout), 32'h1);
      chk("wd.pulse_count", 32'(pulses), 32'h1);
      chk("wd.state_idle", 32'(bif.state), 32'h0);
      tick();
      chk("wd.pulse_one_cycle", 32'(bif.timeout), 32'h0);

      // done coinciding with expiry: done wins, no timeout pulse
      bif.rx_ready = 1'b1; bif.rx_data = 8'h21;
      tick();
      idle_inputs();
      repeat (99) tick();
      chk("wd_done.still_active", 32'(bif.ch_activate), 32'h2);
      bif.ch_done = 4'b0010;
      tick();
      bif.ch_done = '0;
      chk("wd_done.released", 32'(bif.ch_activate), 32'h0);
      chk("wd_done.no_timeout", 32'(bif.timeout), 32'h0);
      tick();
      chk("wd_done.no_late_timeout", 32'(bif.timeout), 32'h0);

      // ---------------- NAK path ----------------
      bif.tx_active = 1'b1;
      bif.rx_ready = 1'b1; bif.rx_data = 8'h55;
      tick();
      bif.rx_ready = 1'b0;
      chk("nak.pulse", 32'(bif.nak), 32'h1);
      chk("nak.no_activate", 32'(bif.ch_activate), 32'h0);
      for (int i = 0; i < 10; i++) begin
         bif.rx_ready = (i == 3);
         bif.rx_data  = 8'h11;
         tick();
         chk("nak.wait_tx_start", 32'(bif.tx_start), 32'h0);
         chk("nak.pulse_once", 32'(bif.nak), 32'h0);
         chk("nak.rx_ignored", 32'(bif.ch_activate), 32'h0);
      end
      bif.rx_ready = 1'b0;
      bif.tx_active = 1'b0;
      tick();
      chk("nak.tx_start", 32'(bif.tx_start), 32'h1);
      chk("nak.tx_data", 32'(bif.tx_data), 32'h15);
      bif.tx_active = 1'b1;
      tick();
      chk("nak.tx_start_once", 32'(bif.tx_start), 32'h0);
      bif.rx_ready = 1'b1; bif.rx_data = 8'h11;
      tick();
      bif.rx_ready = 1'b0;
      chk("nak_wait.rx_ignored", 32'(bif.ch_activate), 32'h0);
      repeat (3) tick();
      bif.tx_active = 1'b0; bif.tx_done = 1'b1;
      tick();
      bif.tx_done = 1'b0;
      bif.rx_ready = 1'b1; bif.rx_data = 8'h11;
      tick();
      bif.rx_ready = 1'b0;
      chk("nak.after_done_act", 32'(bif.ch_activate), 32'h1);
      chk("nak.after_done_state", 32'(bif.state), 32'h11);
      bif.ch_done = 4'b0001;
      tick();
      idle_inputs();

      // ---------------- asynchronous reset ----------------
      bif.rx_ready = 1'b1; bif.rx_data = 8'h71;
      tick();
      bif.rx_ready = 1'b0;
      bif.ch_tx_start = 4'b0100;
      tick();
      chk("rst.pre_tx_start", 32'(bif.tx_start), 32'h1);
      #2 reset = 1'b1;
      #1 check_outs("rst_active", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      tick();
      reset = 1'b0;
      tick();
      check_outs("rst_active.after", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      bif.tx_active = 1'b1;
      bif.rx_ready = 1'b1; bif.rx_data = 8'h55;
      tick();
      bif.rx_ready = 1'b0;
      chk("rst_nak.pulse", 32'(bif.nak), 32'h1);
      tick();
      #2 reset = 1'b1;
      #1 check_outs("rst_nak", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      bif.tx_active = 1'b0;
      tick();
      tick();
      chk("rst_nak.no_stale_start", 32'(bif.tx_start), 32'h0);
      bif.rx_ready = 1'b1; bif.rx_data = 8'h00;
      tick();
      bif.rx_ready = 1'b0;
      check_outs("rst_nak.rx00", 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_inputs(c >= 1500);
         model_step();
         tick();
         check_outs("rnd", e_act, e_state, e_txs, e_txd, e_nak, e_ab, e_to);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
